uart_baud_gen_frac: RTL

- Next-generation UART baud generator for the full-duplex UART core.
- Produces three timing outputs:
  - a single-cycle oversample tick (rx_tick), used by the receiver's mid-bit sampler;
  - a single-cycle bit tick (tx_tick), used by the transmitter;
  - a legacy 50%-duty baud_clk square wave at the bit rate.
- Division is fractional-N, so the average baud error stays well below 0.1%.
- Rates come from seven compile-time presets or from a runtime-loaded custom divisor.

---
 rtl/uart_baud_gen_frac.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
// Fractional-N UART baud generator. It produces an oversample tick for the
// receiver, a bit tick for the transmitter and a 50% duty baud_clk at the
// bit rate. The rate comes from seven compile-time presets or from a
// runtime-loaded custom divisor.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        generator enable (low holds the generator in restart)
//   baud_sel  0..6 = 2400..115200 presets, 7 = custom divisor
//   cfg_div   custom divisor {int[DIV_W], frac[FRAC_W]}
//   cfg_load  strobe that captures cfg_div into the custom register
//   rx_tick   one-clk oversample pulse
//   tx_tick   one-clk bit pulse, coincident with the wrapping rx_tick
//   baud_clk  square wave at the bit rate, rising mid-bit
//   div_err   high while the active integer divisor is below 2
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              baud_sel,
  input  logic [DIV_W+FRAC_W-1:0] cfg_div,
  input  logic                    cfg_load,
  output logic                    rx_tick,
  output logic                    tx_tick,
  output logic                    baud_clk,
  output logic                    div_err
);

  localparam int unsigned DW    = DIV_W + FRAC_W;
  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(2);

  // Fixed-point divisor CLK_FREQ*2^FRAC_W/(baud*OVERSAMPLE), truncated.
  function automatic logic [DW-1:0] calc_div(input longint unsigned baud);
    longint unsigned full;
    full = (64'(CLK_FREQ) << FRAC_W) / (baud * 64'(OVERSAMPLE));
    return DW'(full);
  endfunction

  localparam logic [DW-1:0] DIV_2400   = calc_div(64'd2400);
  localparam logic [DW-1:0] DIV_4800   = calc_div(64'd4800);
  localparam logic [DW-1:0] DIV_9600   = calc_div(64'd9600);
  localparam logic [DW-1:0] DIV_19200  = calc_div(64'd19200);
  localparam logic [DW-1:0] DIV_38400  = calc_div(64'd38400);
  localparam logic [DW-1:0] DIV_57600  = calc_div(64'd57600);
  localparam logic [DW-1:0] DIV_115200 = calc_div(64'd115200);

  // State
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [FRAC_W-1:0] acc_q,     acc_d;
  logic [OS_W-1:0]   os_cnt_q,  os_cnt_d;
  logic              baud_q,    baud_d;
  logic              rx_tick_q, rx_tick_d;
  logic              tx_tick_q, tx_tick_d;
  logic              div_err_q, div_err_d;
  logic [DW-1:0]     custom_q,  custom_d;
  logic [DW-1:0]     div_q,     div_d;
  logic [2:0]        sel_q,     sel_d;

  // Intermediate combinational values
  logic [DW-1:0]     preset_div;
  logic [DIV_W-1:0]  div_int;
  logic [DIV_W-1:0]  eff_int;
  logic [FRAC_W:0]   frac_sum;
  logic [CNT_W-1:0]  interval;
  logic [CNT_W-1:0]  cnt_inc;
  logic              restart;

  // Preset divisor table
  always_comb begin
    preset_div = DIV_9600;
    case (baud_sel)
      3'd0:    preset_div = DIV_2400;
      3'd1:    preset_div = DIV_4800;
      3'd2:    preset_div = DIV_9600;
      3'd3:    preset_div = DIV_19200;
      3'd4:    preset_div = DIV_38400;
      3'd5:    preset_div = DIV_57600;
      3'd6:    preset_div = DIV_115200;
      default: preset_div = DIV_9600;
    endcase
  end

  // Active divisor selection. The mux looks at the custom register's next
  // value so that a cfg_load (or reset) with baud_sel=7 takes effect from
  // the very restart edge instead of one clock late.
  always_comb begin
    custom_d  = cfg_load ? cfg_div : custom_q;
    sel_d     = baud_sel;
    div_d     = preset_div;
    if (baud_sel == 3'd7) begin
      div_d = rst ? DIV_9600 : custom_d;
    end
    div_err_d = (div_d[DW-1:FRAC_W] < MIN_INT);
  end

  // Interval length: clamped integer part plus carry of acc + frac
  always_comb begin
    div_int  = div_q[DW-1:FRAC_W];
    eff_int  = (div_int < MIN_INT) ? MIN_INT : div_int;
    frac_sum = {1'b0, acc_q} + {1'b0, div_q[FRAC_W-1:0]};
    interval = CNT_W'(eff_int) + CNT_W'(frac_sum[FRAC_W]);
    cnt_inc  = cnt_q + CNT_W'(1);
    restart  = !en || cfg_load || (baud_sel != sel_q);
  end

  // Counter / tick generation
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    os_cnt_d  = os_cnt_q;
    baud_d    = baud_q;
    rx_tick_d = 1'b0;
    tx_tick_d = 1'b0;
    if (restart) begin
      cnt_d    = '0;
      acc_d    = '0;
      os_cnt_d = '0;
      baud_d   = 1'b0;
    end else if (cnt_inc == interval) begin
      cnt_d     = '0;
      acc_d     = frac_sum[FRAC_W-1:0];
      rx_tick_d = 1'b1;
      os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      tx_tick_d = (os_cnt_q == OS_LAST);
      // Toggle at mid-bit and at the bit boundary for 50% duty
      if ((os_cnt_q == OS_HALF) || (os_cnt_q == OS_LAST)) begin
        baud_d = ~baud_q;
      end
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // Divisor and select history track their inputs every cycle, including
  // during reset, so no spurious restart follows reset release.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    div_q <= div_d;
  end

  // Registered state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      os_cnt_q  <= '0;
      baud_q    <= 1'b0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
      div_err_q <= 1'b0;
      custom_q  <= DIV_9600;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      os_cnt_q  <= os_cnt_d;
      baud_q    <= baud_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
      div_err_q <= div_err_d;
      custom_q  <= custom_d;
    end
  end

  assign rx_tick  = rx_tick_q;
  assign tx_tick  = tx_tick_q;
  assign baud_clk = baud_q;
  assign div_err  = div_err_q;

endmodule
